// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Frame scheduler for a serial "1101" Mealy sequence detector. A parallel
//   frame is accepted over a valid/ready handshake, the detector is cleared
//   for one cycle, then the frame is streamed MSB-first into the detector,
//   one bit per clock. Detector hits are counted (saturating) and the total
//   is reported with a one-cycle done pulse.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   frame_valid  in   frame_data valid this cycle
//   frame_data   in   FRAME_W-bit frame, bit FRAME_W-1 sent first
//   frame_ready  out  controller can accept a frame (IDLE, not in reset)
//   det_rst      out  detector reset (reset or CLEAR)
//   det_din      out  detector serial input
//   det_y        in   detector Mealy output
//   busy         out  frame in progress (CLEAR or SHIFT)
//   done         out  one-cycle pulse, match_count final
//   match_count  out  matches in last frame, held until next accept
module seq_detect_ctrl #(
  parameter int FRAME_W = 16,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_valid,
  input  logic [FRAME_W-1:0] frame_data,
  output logic               frame_ready,
  output logic               det_rst,
  output logic               det_din,
  input  logic               det_y,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   match_count
);

  localparam int BCW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_W - 1);

  logic [1:0]         state;
  logic [FRAME_W-1:0] shreg;
  logic [BCW-1:0]     bit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      match_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_valid) begin
            shreg       <= frame_data;
            match_count <= '0;
            bit_cnt     <= '0;
            state       <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // det_y is the detector's response to the bit currently on det_din
          if (det_y && (match_count != '1)) begin
            match_count <= match_count + CNT_W'(1);
          end
          shreg   <= {shreg[FRAME_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + BCW'(1);
          if (bit_cnt == LAST_BIT) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs depend only on state, registers and rst; frame_valid and det_y
  // never reach an output combinationally.
  always_comb begin
    frame_ready = (state == ST_IDLE) && !rst;
    det_rst     = rst || (state == ST_CLEAR);
    det_din     = (state == ST_SHIFT) ? shreg[FRAME_W-1] : 1'b0;
    busy        = (state == ST_CLEAR) || (state == ST_SHIFT);
    done        = (state == ST_DONE);
  end

endmodule
